alu_serial_ctrl: RTL and testbench



---
 rtl/alu_serial_ctrl.sv | 92 +++++++++
 tb/tb_alu_serial_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer that steps one shared adder/gate cell
// LSB-first across a WIDTH-bit operation, latching operands on a start handshake.
module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b;
   logic [WIDTH-2:0] r_res;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_c;
   logic             w_ai, w_bi, w_arith, w_sum, w_cy, w_s, w_last, w_acc;
   logic [WIDTH-1:0] w_y;
   assign w_ai    = r_a[0];
   assign w_arith = (r_op == 3'b000) || (r_op == 3'b001) || (r_op == 3'b111);
   assign w_bi    = (r_op == 3'b001) ? ~r_b[0] : (r_op == 3'b111) ? 1'b0 : r_b[0];
   assign w_sum   = w_ai ^ w_bi ^ r_c;
   assign w_cy    = (w_ai & w_bi) | (r_c & (w_ai ^ w_bi));
   assign w_s     = w_arith          ? w_sum :
                    (r_op == 3'b010) ? (w_ai & r_b[0]) :
                    (r_op == 3'b011) ? (w_ai | r_b[0]) :
                    (r_op == 3'b100) ? (w_ai ^ r_b[0]) :
                    (r_op == 3'b101) ? ~(w_ai & r_b[0]) : ~w_ai;
   assign w_last  = r_cnt == CW'(WIDTH - 1);
   // the current bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB
   assign w_y     = {w_s, r_res};
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      w_acc  = 1'b0;
      case (r_state)
         IDLE: begin
            w_acc  = start;
            w_next = start ? RUN : IDLE;
         end
         RUN: begin
            busy   = 1'b1;
            w_next = w_last ? DONE : RUN;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_c     <= 1'b0;
         y       <= '0;
         cout    <= 1'b0;
         zero    <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_cnt <= '0;
            r_c   <= (op == 3'b001) || (op == 3'b111);
         end else if (busy) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_y[WIDTH-1:1];
            r_cnt <= r_cnt + 1'b1;
            if (w_arith) r_c <= w_cy;
            if (w_last) begin
               y    <= w_y;
               cout <= w_arith & w_cy;
               zero <= w_y == '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed self-checking bench for the bit-serial ALU sequencer.
module tb_alu_serial_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       busy, done, cout, zero;
   logic [7:0] y;
   int checks = 0;
   int errors = 0;
   int lat, nbusy, stable, after;
   logic [7:0] y0;

   alu_serial_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .y(y), .cout(cout), .zero(zero)
   );

   always #5 clk = ~clk;

   // waits for done after the accepting edge, tracking latency, busy cycles and y stability
   task automatic wait_done();
      lat = 0;
      stable = 1;
      y0 = y;
      nbusy = busy ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         if (busy) nbusy++;
         if (y !== y0) stable = 0;
      end
      @(posedge clk);
      #1;
      after = {30'd0, done, busy};
   endtask

   task automatic run_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
      @(posedge clk);
      #1;
      start = 1'b1; op = o; a = aa; b = bb;
      @(posedge clk);
      #1;
      start = 1'b0; op = ~o; a = ~aa; b = bb ^ 8'h5A;
      wait_done();
   endtask

   task automatic chk_res(input string nm, input logic [7:0] ey, input logic ec, input logic ez);
      checks++;
      if (y !== ey || cout !== ec || zero !== ez || lat != 8) begin
         errors++;
         $display("FAIL %s: got y=%h cout=%b zero=%b lat=%0d, expected y=%h cout=%b zero=%b lat=8",
                  nm, y, cout, zero, lat, ey, ec, ez);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_ctl: busy=%b done=%b, expected 0 0", busy, done);
      end
      checks++;
      if (y !== 8'h00 || cout !== 1'b0 || zero !== 1'b1) begin
         errors++; $display("FAIL reset_out: y=%h cout=%b zero=%b, expected 00 0 1", y, cout, zero);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_start: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_add();
      run_op(3'b000, 8'hFF, 8'h01);
      chk_res("add_ff_01", 8'h00, 1'b1, 1'b1);
      checks++;
      if (nbusy != 8) begin
         errors++; $display("FAIL add_busy: busy cycles=%0d, expected 8", nbusy);
      end
      checks++;
      if (after != 0) begin
         errors++; $display("FAIL add_pulse: done/busy after pulse=%0d, expected 0", after);
      end
   endtask

   task automatic test_sub();
      run_op(3'b001, 8'h05, 8'h07);
      chk_res("sub_05_07", 8'hFE, 1'b0, 1'b0);
      checks++;
      if (stable != 1) begin
         errors++; $display("FAIL sub_stable: y changed during run (stable=%0d), expected 1", stable);
      end
      run_op(3'b001, 8'h07, 8'h05);
      chk_res("sub_07_05", 8'h02, 1'b1, 1'b0);
      checks++;
      if (stable != 1) begin
         errors++; $display("FAIL sub2_stable: y changed during run (stable=%0d), expected 1", stable);
      end
   endtask

   task automatic test_logic();
      logic [2:0] ops [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
      logic [7:0] exp [5] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h5A};
      string      nms [5] = '{"and", "or", "xor", "nand", "not"};
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], 8'hA5, 8'h0F);
         chk_res(nms[i], exp[i], 1'b0, 1'b0);
      end
   endtask

   task automatic test_inc();
      run_op(3'b111, 8'hFF, 8'h3C);
      chk_res("inc_ff", 8'h00, 1'b1, 1'b1);
      run_op(3'b111, 8'h41, 8'hFF);
      chk_res("inc_41", 8'h42, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(posedge clk);
      #1;
      start = 1'b1; op = 3'b000; a = 8'h12; b = 8'h34;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; op = 3'b001; a = 8'h77; b = 8'h99;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      lat = lat + 3;
      chk_res("b2b_add", 8'h46, 1'b0, 1'b0);
      checks++;
      if (after != 0) begin
         errors++; $display("FAIL b2b_idle: done/busy after=%0d, expected 0", after);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL b2b_no_accept: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_held_start();
      @(posedge clk);
      #1;
      start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h02;
      @(posedge clk);
      #1;
      wait_done();
      chk_res("held_add", 8'h03, 1'b0, 1'b0);
      checks++;
      if (after != 0) begin
         errors++; $display("FAIL held_idle: done/busy after=%0d, expected 0", after);
      end
      a = 8'h10; b = 8'h20;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL held_reaccept: busy=%b, expected 1", busy);
      end
      wait_done();
      chk_res("held_add2", 8'h30, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      int nd;
      @(posedge clk);
      #1;
      start = 1'b1; op = 3'b000; a = 8'h80; b = 8'h80;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || y !== 8'h00 || cout !== 1'b0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b y=%h cout=%b zero=%b, expected 0 0 00 0 1",
                  busy, done, y, cout, zero);
      end
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) nd++;
      end
      checks++;
      if (nd != 0) begin
         errors++; $display("FAIL abort_no_done: active cycles=%0d, expected 0", nd);
      end
      run_op(3'b000, 8'h01, 8'h01);
      chk_res("abort_fresh", 8'h02, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_inc();
      test_back_to_back();
      test_held_start();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
